nonrestoring_divider: RTL

//  Sequential radix-2 non-restoring divider. Companion to the Booth radix-2 multiplier.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_datapath.sv | 78 +++++++
 rtl/nonrestoring_divider.sv | 122 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the radix-2 non-restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } div_state_t;

  // Iteration counter must hold WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_datapath.sv
// A/Q/M shift-register datapath of the non-restoring divider: one
// shift-and-add/subtract iteration per strobe, plus the iteration counter.
module div_datapath
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ldA,
  input  logic             ldQ,
  input  logic             ldM,
  input  logic             shift,
  input  logic             addsub,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] m_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] rem_mag,
  output logic             m_zero,
  output logic             cnt_last
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   m_ext, a_shl, a_sum;

  assign m_ext = {1'b0, m_q};

  // The add/subtract choice uses the sign of A before the shift; the shifted
  // value may wrap in WIDTH+1 bits but the sum lands back in range.
  always_comb begin
    a_shl = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    a_sum = a_q[WIDTH] ? (a_shl + m_ext) : (a_shl - m_ext);
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    if (ldA) a_d = '0;
    if (ldQ) begin
      q_d   = q_in;
      cnt_d = CW'(WIDTH);
    end
    if (ldM) m_d = m_in;
    if (shift) begin
      a_d   = a_shl;
      q_d   = {q_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - 1'b1;
      if (addsub) begin
        a_d    = a_sum;
        q_d[0] = ~a_sum[WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_out    = q_q;
  assign rem_mag  = a_q[WIDTH] ? (a_q[WIDTH-1:0] + m_q) : a_q[WIDTH-1:0];
  assign m_zero   = (m_q == '0);
  assign cnt_last = (cnt_q == CW'(1));

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential radix-2 non-restoring divider with start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands and results.
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quot_q, rem_q, dvd_q, dvs_q;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, q_mag, r_mag, quot_fix, rem_fix;
  logic             m_zero, cnt_last, ld, it;

`ifdef DIV_SIGNED_EN
  logic q_neg_q, r_neg_q;

  assign dvd_mag  = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
  assign dvs_mag  = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
  assign quot_fix = q_neg_q ? -q_mag : q_mag;
  assign rem_fix  = r_neg_q ? -r_mag : r_mag;
`else
  assign dvd_mag  = dvd_q;
  assign dvs_mag  = dvs_q;
  assign quot_fix = q_mag;
  assign rem_fix  = r_mag;
`endif

  assign ld = (state_q == LOAD);
  assign it = (state_q == ITER);

  div_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .ldA     (ld),
    .ldQ     (ld),
    .ldM     (ld),
    .shift   (it),
    .addsub  (it),
    .q_in    (dvd_mag),
    .m_in    (dvs_mag),
    .q_out   (q_mag),
    .rem_mag (r_mag),
    .m_zero  (m_zero),
    .cnt_last(cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
`ifdef DIV_SIGNED_EN
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
`ifdef DIV_SIGNED_EN
          q_neg_q <= dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
          r_neg_q <= dvd_q[WIDTH-1];
`endif
          state_q <= ITER;
        end
        ITER: begin
          if (cnt_last) state_q <= FIX;
        end
        FIX: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          dbz_q   <= m_zero;
          // Zero divisor reports the untouched original dividend.
          if (m_zero) begin
            quot_q <= '1;
            rem_q  <= dvd_q;
          end else begin
            quot_q <= quot_fix;
            rem_q  <= rem_fix;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
